// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One full-subtractor bit slice (x - y - bin) built from two half-subtractor
// cells; the two partial borrows are ORed to form the slice borrow.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x      (x),
        .y      (y),
        .diff   (d1),
        .borrow (b1)
    );

    // Second cell subtracts the incoming borrow from the partial difference;
    // its borrow equals ~(x^y) & bin.
    half_subtractor u_hs1 (
        .x      (d1),
        .y      (bin),
        .diff   (d),
        .borrow (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Combinational half-subtractor cell: diff = x - y, borrow when x < y.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic borrow
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// A single full_subtractor_bit slice is reused every cycle with the borrow
// held in a register between slices.
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed overflow
// output, computed during the MSB slice.
//
// Handshake: start is sampled on any edge where busy=0 (IDLE or DONE); that
// edge captures a/b. busy stays high for WIDTH cycles, then done pulses for
// one cycle with diff/borrow_out (and overflow) valid. start while busy=1 is
// ignored. Results hold until the next accepted start.
//
// fsm_state mirrors the internal state (IDLE=0, SHIFT=1, DONE=2) for debug.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       fsm_state
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             x;
    logic             y;
    logic             d;
    logic             bout;

    assign x      = a_sh[0];
    assign y      = b_sh[0];
    assign accept = start && (state != SHIFT);

    full_subtractor_bit u_bit (
        .x    (x),
        .y    (y),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: a start in DONE goes straight back to SHIFT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift one slice per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            brw  <= bout;
            diff <= {d, diff[WIDTH-1:1]};
            // Counter parks at LAST so it never wraps.
            if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Signed overflow: operand signs differ and result sign differs from a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (!accept && (state == SHIFT) && (cnt == LAST)) begin
            overflow <= (x ^ y) & (x ^ d);
        end
    end
`endif

    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);
    assign borrow_out = brw;
    assign fsm_state  = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vectors with hand-computed
// results pushed into an expected queue; a negedge monitor pops and compares
// on every done pulse.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 2;  // {overflow, borrow, diff}

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic [1:0]       fsm_state;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_push   = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .fsm_state  (fsm_state)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        exp_q.push_back({eo, eb, ed});
        n_push++;
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(mon_e[WIDTH-1:0]));
                check("borrow_out", 32'(borrow_out), 32'(mon_e[WIDTH]));
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("overflow", 32'(overflow), 32'(mon_e[WIDTH+1]));
`endif
            end
        end
    end

    // Wait until done is seen #1 after a posedge; returns cycles waited.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < 40);
    endtask

    // One complete operation with a single-cycle start pulse.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int k;
        @(negedge clk);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        a = av;
        b = bv;
        start = 1'b1;
        push(ed, eb, eo);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(k);
        check("done_latency", 32'(k), 32'(WIDTH));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int t[3];

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic vectors, including borrow and signed-overflow boundaries.
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // start while busy must be ignored.
        @(negedge clk);
        a = 8'h0A;
        b = 8'h04;
        start = 1'b1;
        push(8'h06, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ignore", 32'(busy), 32'd1);
        wait_done(k);
        check("ignore_done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("ignore_single_done", 32'(done), 32'd0);

        // start held high: each accept happens on the edge closing DONE, so
        // done pulses land WIDTH+1 cycles apart.
        @(negedge clk);
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        for (int i = 0; i < 3; i++) push(8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            k = 0;
            @(negedge clk);
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            t[i] = cyc;
            if (k >= 40) check("b2b_done_seen", 32'(done), 32'd1);
        end
        start = 1'b0;
        check("b2b_spacing_0", 32'(t[1] - t[0]), 32'(WIDTH + 1));
        check("b2b_spacing_1", 32'(t[2] - t[1]), 32'(WIDTH + 1));
        @(posedge clk);
        #1;
        check("b2b_back_idle", 32'(fsm_state), 32'(IDLE));

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        a = 8'h55;
        b = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(fsm_state), 32'(IDLE));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("abort_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(fsm_state), 32'(IDLE));
        run_op(8'h09, 8'h09, 8'h00, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
